// File: rtl/hdc_classifier.sv
// -----------------------------------------------------------------------------
// hdc_classifier
// Hyperdimensional-computing classifier. Each input beat binds a value and a
// position hypervector (XOR). SMP_SIZE beats are bundled by per-bit majority
// into a sample hypervector. In train mode SET_SIZE samples are bundled again
// and written to the associative memory row of the given label. In predict
// mode the sample becomes the query and every trained class is scored by
// Hamming similarity, one class per cycle; the best class is reported.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   im_value   value hypervector of the current feature
//   im_pos     position hypervector of the current feature
//   in_valid   feature beat valid
//   in_ready   block accepts a beat (ACCUM state only)
//   mode       0 = train, 1 = predict; sampled on the first beat of set/sample
//   label      training class; sampled with mode
//   out_valid  prediction valid
//   out_ready  consumer accepts prediction
//   predict    winning class index
//   score      matching-bit count of the winner
//   no_model   no class was trained when the prediction was made
// -----------------------------------------------------------------------------
module hdc_classifier #(
    parameter int DIM      = 1024,
    parameter int CLS_NUM  = 10,
    parameter int SMP_SIZE = 16,
    parameter int SET_SIZE = 8,
    parameter int CLS_DW   = $clog2(CLS_NUM),
    parameter int SIM_DW   = $clog2(DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM-1:0]    im_value,
    input  logic [DIM-1:0]    im_pos,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [CLS_DW-1:0] label,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_DW-1:0] predict,
    output logic [SIM_DW-1:0] score,
    output logic              no_model
);

    localparam int SW  = $clog2(SMP_SIZE + 1);  // sample counter width
    localparam int STW = $clog2(SET_SIZE + 1);  // set counter width

    typedef enum logic [1:0] {ACCUM, WRITE, SEARCH, RESULT} state_t;

    state_t              state_q, state_d;
    logic                alive_q;         // low until first edge after reset release
    logic [SW-1:0]       beat_q;
    logic [STW-1:0]      smp_idx_q;
    logic                mode_q;
    logic [CLS_DW-1:0]   label_q;
    logic [DIM-1:0]      hv_q;            // set result (train) or query (predict)
    logic [CLS_NUM-1:0]  trained_q;
    logic [CLS_DW-1:0]   idx_q, best_idx_q;
    logic [SIM_DW-1:0]   best_sim_q;
    logic                found_q;
    logic                out_valid_q, no_model_q;
    logic [CLS_DW-1:0]   predict_q;
    logic [SIM_DW-1:0]   score_q;

    logic [DIM-1:0]      am_mem [CLS_NUM];

    logic [DIM-1:0]      bound, smp_hv, set_hv, am_rd;
    logic                beat_fire, first_beat, cur_mode, last_beat, last_smp;
    logic                smp_done, train_done, label_ok, last_idx, cand;
    logic [SIM_DW-1:0]   sim;

    function automatic logic [SIM_DW-1:0] popcnt(input logic [DIM-1:0] v);
        logic [SIM_DW-1:0] c;
        c = '0;
        for (int k = 0; k < DIM; k++) c = c + SIM_DW'(v[k]);
        return c;
    endfunction

    assign in_ready   = (state_q == ACCUM) && alive_q;
    assign beat_fire  = in_valid && in_ready;
    assign bound      = im_value ^ im_pos;
    // mode/label only matter on the very first beat of a set (train) or of a
    // sample (predict never advances smp_idx_q, so every sample starts a set).
    assign first_beat = (beat_q == '0) && (smp_idx_q == '0);
    assign cur_mode   = first_beat ? mode : mode_q;
    assign last_beat  = (beat_q == SW'(SMP_SIZE - 1));
    assign last_smp   = (smp_idx_q == STW'(SET_SIZE - 1));
    assign smp_done   = beat_fire && last_beat;
    assign train_done = smp_done && !cur_mode;
    assign label_ok   = (32'(label_q) < CLS_NUM);

    // Per-bit majority counters for both bundling levels.
    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_bit
            logic [SW-1:0]  smp_cnt_q;
            logic [SW-1:0]  smp_sum;
            logic [STW-1:0] set_cnt_q;
            logic [STW-1:0] set_sum;

            assign smp_sum     = smp_cnt_q + SW'(bound[gi]);
            assign smp_hv[gi]  = ((32'(smp_sum) << 1) > 32'(SMP_SIZE));
            assign set_sum     = set_cnt_q + STW'(smp_hv[gi]);
            assign set_hv[gi]  = ((32'(set_sum) << 1) > 32'(SET_SIZE));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    smp_cnt_q <= '0;
                    set_cnt_q <= '0;
                end else begin
                    // Clearing on the last beat lets the next sample start
                    // on the very next cycle.
                    if (beat_fire) smp_cnt_q <= last_beat ? '0 : smp_sum;
                    if (train_done) set_cnt_q <= last_smp ? '0 : set_sum;
                end
            end
        end
    endgenerate

    // Search: combinational AM read so each class is scored in its own cycle
    // and the result appears CLS_NUM edges after the last predict beat.
    assign am_rd    = am_mem[idx_q];
    assign sim      = popcnt(~(am_rd ^ hv_q));
    assign last_idx = (idx_q == CLS_DW'(CLS_NUM - 1));
    assign cand     = trained_q[idx_q] && (!found_q || (sim > best_sim_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (smp_done) begin
                    if (cur_mode)      state_d = SEARCH;
                    else if (last_smp) state_d = WRITE;
                end
            end
            WRITE:   state_d = ACCUM;
            SEARCH:  if (last_idx) state_d = RESULT;
            RESULT:  if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q     <= 1'b0;
            beat_q      <= '0;
            smp_idx_q   <= '0;
            mode_q      <= 1'b0;
            label_q     <= '0;
            hv_q        <= '0;
            trained_q   <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_sim_q  <= '0;
            found_q     <= 1'b0;
            out_valid_q <= 1'b0;
            predict_q   <= '0;
            score_q     <= '0;
            no_model_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (beat_fire) begin
                beat_q <= last_beat ? '0 : beat_q + SW'(1);
                if (first_beat) begin
                    mode_q  <= mode;
                    label_q <= label;
                end
            end
            if (smp_done) begin
                if (cur_mode) begin
                    hv_q       <= smp_hv;
                    idx_q      <= '0;
                    found_q    <= 1'b0;
                    best_sim_q <= '0;
                    best_idx_q <= '0;
                end else begin
                    smp_idx_q <= last_smp ? '0 : smp_idx_q + STW'(1);
                    if (last_smp) hv_q <= set_hv;
                end
            end
            if (state_q == WRITE && label_ok) trained_q[label_q] <= 1'b1;
            if (state_q == SEARCH) begin
                idx_q <= last_idx ? '0 : idx_q + CLS_DW'(1);
                if (cand) begin
                    found_q    <= 1'b1;
                    best_sim_q <= sim;
                    best_idx_q <= idx_q;
                end
                if (last_idx) begin
                    out_valid_q <= 1'b1;
                    predict_q   <= cand ? idx_q : best_idx_q;
                    score_q     <= cand ? sim : best_sim_q;
                    no_model_q  <= !(found_q || cand);
                end
            end
            // Outputs return to zero with the handshake.
            if (state_q == RESULT && out_ready) begin
                out_valid_q <= 1'b0;
                predict_q   <= '0;
                score_q     <= '0;
                no_model_q  <= 1'b0;
            end
        end
    end

    // AM is not reset; trained_q gates every use of a row.
    always_ff @(posedge clk) begin
        if (state_q == WRITE && label_ok) am_mem[label_q] <= hv_q;
    end

    assign out_valid = out_valid_q;
    assign predict   = predict_q;
    assign score     = score_q;
    assign no_model  = no_model_q;

endmodule

// File: tb/tb_hdc_classifier.sv
module tb_hdc_classifier;
    localparam int DIM = 8, CLS_NUM = 4, SMP_SIZE = 3, SET_SIZE = 1;
    localparam int CLS_DW = 2, SIM_DW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIM-1:0]    im_value = '0;
    logic [DIM-1:0]    im_pos = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mode = 1'b0;
    logic [CLS_DW-1:0] label = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CLS_DW-1:0] predict;
    logic [SIM_DW-1:0] score;
    logic              no_model;

    int total = 0;
    int bad = 0;
    int lat;

    always #5 clk = ~clk;

    hdc_classifier #(
        .DIM(DIM), .CLS_NUM(CLS_NUM), .SMP_SIZE(SMP_SIZE), .SET_SIZE(SET_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .im_value(im_value), .im_pos(im_pos),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .label(label),
        .out_valid(out_valid), .out_ready(out_ready), .predict(predict),
        .score(score), .no_model(no_model)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One beat: bound datum is b, split into value/position using pos.
    task automatic send_beat(input logic [7:0] b, input logic [7:0] pos,
                             input logic m, input logic [1:0] l);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout observed=0 expected=1");
        end
        im_value = b ^ pos;
        im_pos   = pos;
        mode     = m;
        label    = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] pos, input logic m, input logic [1:0] l);
        send_beat(b0, pos, m, l);
        send_beat(b1, pos, m, l);
        send_beat(b2, pos, m, l);
        $display("sample mode=%0d label=%0d beats=%h,%h,%h", m, l, b0, b1, b2);
    endtask

    // Called right after the last beat transferred; counts cycles with the
    // transfer cycle as 0, so the first observed cycle here is 1.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL result_timeout observed=0 expected=1");
        end
    endtask

    task automatic check_result(input string tag, input logic [1:0] p, input logic [3:0] s,
                                input logic nm);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_predict"}, 32'(predict), 32'(p));
        check({tag, "_score"}, 32'(score), 32'(s));
        check({tag, "_no_model"}, 32'(no_model), 32'(nm));
        $display("result %s predict=%0d score=%0d no_model=%0d", tag, predict, score, no_model);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ack_predict"}, 32'(predict), 32'd0);
        check({tag, "_ack_score"}, 32'(score), 32'd0);
        check({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_predict", 32'(predict), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_no_model", 32'(no_model), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        // Predict with nothing trained
        send_sample(8'h3C, 8'h3C, 8'h00, 8'h99, 1'b1, 2'd0);
        wait_result(lat);
        check_result("empty", 2'd0, 4'd0, 1'b1);
        ack("empty");

        // Train class 2 with majority of F0,F0,0F -> F0
        send_sample(8'hF0, 8'hF0, 8'h0F, 8'h5A, 1'b0, 2'd2);

        // Query F1 against class 2 only; result cycle T+CLS_NUM+1
        send_sample(8'hF1, 8'hF1, 8'h00, 8'hC3, 1'b1, 2'd0);
        wait_result(lat);
        check("latency", 32'(lat), 32'(CLS_NUM + 1));
        check_result("q_f1", 2'd2, 4'd7, 1'b0);

        // Hold in RESULT with out_ready low
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_predict", 32'(predict), 32'd2);
            check("hold_score", 32'(score), 32'd7);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        $display("hold 10 cycles done");
        ack("q_f1");

        // Classes 1 and 3 identical: tie goes to the lower index
        send_sample(8'hAA, 8'hAA, 8'hAA, 8'h11, 1'b0, 2'd1);
        send_sample(8'hAA, 8'hAA, 8'h55, 8'h00, 1'b0, 2'd3);
        send_sample(8'hAA, 8'hAA, 8'hAA, 8'h77, 1'b1, 2'd0);
        wait_result(lat);
        check_result("tie", 2'd1, 4'd8, 1'b0);
        ack("tie");

        // mode/label changes after the first beat are ignored: trains class 0
        send_beat(8'h0F, 8'h24, 1'b0, 2'd0);
        send_beat(8'h0F, 8'h24, 1'b1, 2'd3);
        send_beat(8'h0F, 8'h24, 1'b1, 2'd3);
        $display("sample midchange trains class 0 with 0f");
        send_sample(8'h0F, 8'h0F, 8'h0F, 8'h00, 1'b1, 2'd0);
        wait_result(lat);
        check_result("midchange", 2'd0, 4'd8, 1'b0);
        ack("midchange");

        // Overwrite class 1 with 55
        send_sample(8'h55, 8'h55, 8'hFF, 8'hE1, 1'b0, 2'd1);
        send_sample(8'h55, 8'h55, 8'h55, 8'h00, 1'b1, 2'd0);
        wait_result(lat);
        check_result("overwrite", 2'd1, 4'd8, 1'b0);
        ack("overwrite");

        // Reset during SEARCH
        send_sample(8'hF0, 8'hF0, 8'hF0, 8'h00, 1'b1, 2'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("srch_rst_valid", 32'(out_valid), 32'd0);
        check("srch_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("srch_rst_no_valid", 32'(out_valid), 32'd0);
        end
        $display("reset during search done");
        send_sample(8'hAA, 8'hAA, 8'hAA, 8'h00, 1'b1, 2'd0);
        wait_result(lat);
        check_result("after_rst", 2'd0, 4'd0, 1'b1);
        ack("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hdc_classifier.md
HDC_CLASSIFIER -- requirements
Module: hdc_classifier

Interface
REQ-001 The block SHALL have parameter DIM, default 1024, hypervector width in bits.
REQ-002 The block SHALL have parameter CLS_NUM, default 10, number of classes (2..256).
REQ-003 The block SHALL have parameter SMP_SIZE, default 16, feature beats bundled per sample.
REQ-004 The block SHALL have parameter SET_SIZE, default 8, samples bundled per training set.
REQ-005 The block SHALL have derived width CLS_DW = $clog2(CLS_NUM); SIM_DW = $clog2(DIM+1).
REQ-006 The block SHALL have ports, one per line:
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 im_value  in  DIM  value hypervector for current feature
 im_pos  in  DIM  position hypervector for current feature
 in_valid  in  1  feature beat valid
 in_ready  out  1  block accepts beat
 mode  in  1  0 = train, 1 = predict; sampled on first beat of a set/sample
 label  in  CLS_DW  training class; sampled with mode
 out_valid  out  1  prediction valid
 out_ready  in  1  consumer accepts prediction
 predict  out  CLS_DW  winning class index
 score  out  SIM_DW  matching-bit count of winner
 no_model  out  1  no class trained at prediction time

Function
REQ-007 A beat SHALL transfer when in_valid && in_ready; bound datum = im_value ^ im_pos.
REQ-008 FSM states SHALL be ACCUM, WRITE, SEARCH, RESULT; reset state ACCUM.
REQ-009 in_ready SHALL be 1 only in ACCUM.
REQ-010 Sample bundling SHALL use per-bit ones counters of width $clog2(SMP_SIZE+1); sample bit = 1 iff 2*ones > SMP_SIZE (ties -> 0).
REQ-011 Counters SHALL clear on the cycle the sample's last beat transfers, so the next sample's beats may follow with no gap.
REQ-012 In train mode, set bundling SHALL apply the same majority rule over SET_SIZE sample hypervectors, counters width $clog2(SET_SIZE+1).
REQ-013 After the SET_SIZE-th sample completes in train mode, FSM SHALL go to WRITE for one cycle, write AM[label], set trained[label], return to ACCUM.
REQ-014 A write SHALL overwrite prior AM[label] content; label >= CLS_NUM SHALL discard the write.
REQ-015 mode/label changes mid-set or mid-sample SHALL be ignored until the next first beat.
REQ-016 In predict mode, the completed sample hypervector SHALL be latched as query and FSM SHALL enter SEARCH.
REQ-017 SEARCH SHALL visit class index 0..CLS_NUM-1, one per cycle, computing sim = popcount(~(AM[i] ^ query)).
REQ-018 Untrained classes SHALL be skipped; the winner is the strictly greatest sim, ties resolved to lowest index.
REQ-019 After index CLS_NUM-1, FSM SHALL enter RESULT with out_valid=1, predict/score holding the winner.
REQ-020 If no class is trained, RESULT SHALL give predict=0, score=0, no_model=1.
REQ-021 Latency: last predict beat transferring at cycle T SHALL give out_valid=1 at cycle T+CLS_NUM+1.
REQ-022 out_valid, predict, score, no_model SHALL hold stable until out_ready=1; the handshake cycle returns FSM to ACCUM.
REQ-023 predict, score, no_model SHALL be 0 whenever out_valid=0.

Reset
REQ-024 On rst_n=0, asynchronously: FSM ACCUM, all counters 0, trained[] = 0, out_valid=0, predict=0, score=0, no_model=0, in_ready deasserts until first clock edge after release.
REQ-025 AM contents SHALL NOT require reset; trained[] gates their use.
REQ-026 Reset mid-set, mid-sample or mid-SEARCH SHALL discard partial work with no AM write.

Verification (DIM=8, CLS_NUM=4, SMP_SIZE=3, SET_SIZE=1)
REQ-027 Train: label=2, bound beats 0xF0,0xF0,0x0F -> AM[2]=0xF0, trained=4'b0100.
REQ-028 Predict, only class 2 trained, query 0xF1 -> predict=2, score=7, out_valid exactly 5 cycles after last beat.
REQ-029 Train classes 1 and 3 both 0xAA, query 0xAA -> predict=1 (tie to lowest), score=8.
REQ-030 Predict after reset with no training -> predict=0, score=0, no_model=1.
REQ-031 Hold out_ready=0 for 10 cycles in RESULT -> outputs stable, in_ready=0; out_ready=1 -> ACCUM next cycle.
REQ-032 Assert rst_n=0 during SEARCH -> out_valid never rises, trained[] cleared, next prediction gives no_model=1.
